// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: ID decode, load-use hazard / flush logic, and the
// ID/EX, EX/MEM, MEM/WB control registers with saturating stall/flush counters.
module pipe_ctrl_unit #(
  parameter int ALUOP_W   = 3,
  parameter int RA_W      = 5,
  parameter bit HAZARD_EN = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        instr_i,
  input  logic               br_taken_i,
  output logic               stall_o,
  output logic               flush_o,
  output logic               illegal_o,
  output logic               id_jump_o,
  output logic [ALUOP_W-1:0] ex_aluop_o,
  output logic               ex_alusrc_o,
  output logic               ex_branch_o,
  output logic               ex_bne_o,
  output logic [RA_W-1:0]    ex_rs_o,
  output logic [RA_W-1:0]    ex_rt_o,
  output logic [RA_W-1:0]    ex_dest_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic [RA_W-1:0]    mem_dest_o,
  output logic               wb_regwrite_o,
  output logic               wb_memtoreg_o,
  output logic [RA_W-1:0]    wb_dest_o,
  output logic [CNT_W-1:0]   stall_cnt_o,
  output logic [CNT_W-1:0]   flush_cnt_o
);

  logic [5:0]      w_opc;
  logic [RA_W-1:0] w_rs, w_rt, w_rd;
  logic            w_rw, w_mr, w_mw, w_mtr, w_alusrc, w_branch, w_bne;
  logic            w_jump, w_illegal, w_uses_rt, w_keep_fld;
  logic [2:0]      w_aluop;
  logic [RA_W-1:0] w_dest;
  logic            w_hazard, w_bubble;

  logic            r_ex_rw, r_ex_mr, r_ex_mw, r_ex_mtr;
  logic            r_mem_rw, r_mem_mtr;

  assign w_opc = instr_i[31:26];
  assign w_rs  = RA_W'(instr_i[25:21]);
  assign w_rt  = RA_W'(instr_i[20:16]);
  assign w_rd  = RA_W'(instr_i[15:11]);

  // Opcode decode; an all-zero word and unknown opcodes both yield an empty bundle.
  always_comb begin
    w_rw       = 1'b0;
    w_mr       = 1'b0;
    w_mw       = 1'b0;
    w_mtr      = 1'b0;
    w_alusrc   = 1'b0;
    w_branch   = 1'b0;
    w_bne      = 1'b0;
    w_aluop    = 3'b000;
    w_dest     = '0;
    w_jump     = 1'b0;
    w_illegal  = 1'b0;
    w_uses_rt  = 1'b0;
    w_keep_fld = 1'b0;
    if (instr_i == 32'h0000_0000) begin
      w_keep_fld = 1'b0;
    end else begin
      w_keep_fld = 1'b1;
      case (w_opc)
        6'b000000: begin
          w_rw = 1'b1; w_aluop = 3'b010; w_dest = w_rd; w_uses_rt = 1'b1;
        end
        6'b100011: begin
          w_rw = 1'b1; w_mr = 1'b1; w_mtr = 1'b1; w_alusrc = 1'b1; w_dest = w_rt;
        end
        6'b101011: begin
          w_mw = 1'b1; w_alusrc = 1'b1; w_uses_rt = 1'b1;
        end
        6'b000100: begin
          w_branch = 1'b1; w_aluop = 3'b001; w_uses_rt = 1'b1;
        end
        6'b000101: begin
          w_branch = 1'b1; w_bne = 1'b1; w_aluop = 3'b001; w_uses_rt = 1'b1;
        end
        6'b001000: begin
          w_rw = 1'b1; w_alusrc = 1'b1; w_dest = w_rt;
        end
        6'b001100: begin
          w_rw = 1'b1; w_alusrc = 1'b1; w_dest = w_rt; w_aluop = 3'b011;
        end
        6'b001101: begin
          w_rw = 1'b1; w_alusrc = 1'b1; w_dest = w_rt; w_aluop = 3'b100;
        end
        6'b001010: begin
          w_rw = 1'b1; w_alusrc = 1'b1; w_dest = w_rt; w_aluop = 3'b111;
        end
        6'b000010: begin
          w_jump = 1'b1; w_keep_fld = 1'b0;
        end
        default: begin
          w_illegal = 1'b1; w_keep_fld = 1'b0;
        end
      endcase
    end
  end

  // rt only counts as a source for instructions that actually read it
  assign w_hazard = HAZARD_EN && r_ex_mr && (ex_rt_o != '0) &&
                    ((ex_rt_o == w_rs) || (w_uses_rt && (ex_rt_o == w_rt)));
  assign stall_o   = w_hazard && !br_taken_i;
  assign flush_o   = br_taken_i || w_jump;
  assign w_bubble  = br_taken_i || w_hazard;
  assign illegal_o = w_illegal;
  assign id_jump_o = w_jump;

  // Control pipeline registers; EX/MEM and MEM/WB advance every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_aluop_o <= '0; ex_alusrc_o <= 1'b0; ex_branch_o <= 1'b0; ex_bne_o <= 1'b0;
      ex_rs_o <= '0; ex_rt_o <= '0; ex_dest_o <= '0;
      r_ex_rw <= 1'b0; r_ex_mr <= 1'b0; r_ex_mw <= 1'b0; r_ex_mtr <= 1'b0;
      mem_read_o <= 1'b0; mem_write_o <= 1'b0; mem_dest_o <= '0;
      r_mem_rw <= 1'b0; r_mem_mtr <= 1'b0;
      wb_regwrite_o <= 1'b0; wb_memtoreg_o <= 1'b0; wb_dest_o <= '0;
    end else begin
      if (w_bubble) begin
        ex_aluop_o <= '0; ex_alusrc_o <= 1'b0; ex_branch_o <= 1'b0; ex_bne_o <= 1'b0;
        ex_rs_o <= '0; ex_rt_o <= '0; ex_dest_o <= '0;
        r_ex_rw <= 1'b0; r_ex_mr <= 1'b0; r_ex_mw <= 1'b0; r_ex_mtr <= 1'b0;
      end else begin
        ex_aluop_o  <= ALUOP_W'(w_aluop);
        ex_alusrc_o <= w_alusrc;
        ex_branch_o <= w_branch;
        ex_bne_o    <= w_bne;
        ex_rs_o     <= w_keep_fld ? w_rs : '0;
        ex_rt_o     <= w_keep_fld ? w_rt : '0;
        ex_dest_o   <= w_dest;
        r_ex_rw <= w_rw; r_ex_mr <= w_mr; r_ex_mw <= w_mw; r_ex_mtr <= w_mtr;
      end
      mem_read_o    <= r_ex_mr;
      mem_write_o   <= r_ex_mw;
      mem_dest_o    <= ex_dest_o;
      r_mem_rw      <= r_ex_rw;
      r_mem_mtr     <= r_ex_mtr;
      wb_regwrite_o <= r_mem_rw;
      wb_memtoreg_o <= r_mem_mtr;
      wb_dest_o     <= mem_dest_o;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall_o && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      else                                stall_cnt_o <= stall_cnt_o;
      if (flush_o && (flush_cnt_o != '1)) flush_cnt_o <= flush_cnt_o + CNT_W'(1);
      else                                flush_cnt_o <= flush_cnt_o;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench for pipe_ctrl_unit: a reference decoder/hazard model pushes
// expected bundles into per-stage queues that are popped as the pipeline advances.
module tb_pipe_ctrl_unit;

  logic        clk, rst_n, br_taken_i;
  logic [31:0] instr_i;
  logic        stall_o, flush_o, illegal_o, id_jump_o;
  logic [2:0]  ex_aluop_o;
  logic        ex_alusrc_o, ex_branch_o, ex_bne_o;
  logic [4:0]  ex_rs_o, ex_rt_o, ex_dest_o;
  logic        mem_read_o, mem_write_o;
  logic [4:0]  mem_dest_o;
  logic        wb_regwrite_o, wb_memtoreg_o;
  logic [4:0]  wb_dest_o;
  logic [3:0]  stall_cnt_o, flush_cnt_o;

  typedef struct packed {
    logic [2:0] aluop;
    logic       alusrc, branch, bne, rw, mr, mw, mtr;
    logic [4:0] rs, rt, dest;
  } bun_t;

  bun_t exq[$], memq[$], wbq[$];
  bun_t m_ex;
  int   m_sc, m_fc;
  int   n_cmp = 0, n_err = 0;

  pipe_ctrl_unit #(.ALUOP_W(3), .RA_W(5), .HAZARD_EN(1'b1), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .instr_i(instr_i), .br_taken_i(br_taken_i),
    .stall_o(stall_o), .flush_o(flush_o), .illegal_o(illegal_o), .id_jump_o(id_jump_o),
    .ex_aluop_o(ex_aluop_o), .ex_alusrc_o(ex_alusrc_o), .ex_branch_o(ex_branch_o),
    .ex_bne_o(ex_bne_o), .ex_rs_o(ex_rs_o), .ex_rt_o(ex_rt_o), .ex_dest_o(ex_dest_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .mem_dest_o(mem_dest_o),
    .wb_regwrite_o(wb_regwrite_o), .wb_memtoreg_o(wb_memtoreg_o), .wb_dest_o(wb_dest_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [4:0] rd);
    return {op, rs, rt, rd, 11'h000};
  endfunction

  function automatic bun_t ref_dec(input logic [31:0] ins, output logic ill, output logic jmp);
    bun_t b;
    b = '0; ill = 1'b0; jmp = 1'b0;
    case (ins[31:26])
      6'h00: if (ins != 32'h0) begin b.rw = 1'b1; b.aluop = 3'b010; b.dest = ins[15:11]; end
      6'h23: begin b.rw = 1'b1; b.mr = 1'b1; b.mtr = 1'b1; b.alusrc = 1'b1; b.dest = ins[20:16]; end
      6'h2B: begin b.mw = 1'b1; b.alusrc = 1'b1; end
      6'h04: begin b.branch = 1'b1; b.aluop = 3'b001; end
      6'h05: begin b.branch = 1'b1; b.bne = 1'b1; b.aluop = 3'b001; end
      6'h08: begin b.rw = 1'b1; b.alusrc = 1'b1; b.dest = ins[20:16]; b.aluop = 3'b000; end
      6'h0C: begin b.rw = 1'b1; b.alusrc = 1'b1; b.dest = ins[20:16]; b.aluop = 3'b011; end
      6'h0D: begin b.rw = 1'b1; b.alusrc = 1'b1; b.dest = ins[20:16]; b.aluop = 3'b100; end
      6'h0A: begin b.rw = 1'b1; b.alusrc = 1'b1; b.dest = ins[20:16]; b.aluop = 3'b111; end
      6'h02: jmp = 1'b1;
      default: ill = 1'b1;
    endcase
    if (!ill && !jmp && ins != 32'h0) begin
      b.rs = ins[25:21];
      b.rt = ins[20:16];
    end
    return b;
  endfunction

  task automatic step(input logic [31:0] ins, input logic br);
    bun_t b, e;
    logic ill, jmp, hz, st, fl, urt;
    logic [5:0] op;
    instr_i = ins;
    br_taken_i = br;
    #1;
    op  = ins[31:26];
    b   = ref_dec(ins, ill, jmp);
    urt = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);
    hz  = m_ex.mr && (m_ex.rt != 5'd0) &&
          ((m_ex.rt == ins[25:21]) || (urt && (m_ex.rt == ins[20:16])));
    st  = hz && !br;
    fl  = br || jmp;
    check_val("comb{stall,flush,ill,jmp}", {28'h0, stall_o, flush_o, illegal_o, id_jump_o},
              {28'h0, st, fl, ill, jmp});
    if (br || hz) b = '0;
    if (st && m_sc != 15) m_sc++;
    if (fl && m_fc != 15) m_fc++;
    exq.push_back(b);
    memq.push_back(b);
    wbq.push_back(b);
    @(posedge clk);
    #1;
    m_ex = b;
    e = exq.pop_front();
    check_val("ex", {11'h0, ex_aluop_o, ex_alusrc_o, ex_branch_o, ex_bne_o, ex_rs_o, ex_rt_o, ex_dest_o},
              {11'h0, e.aluop, e.alusrc, e.branch, e.bne, e.rs, e.rt, e.dest});
    e = memq.pop_front();
    check_val("mem", {25'h0, mem_read_o, mem_write_o, mem_dest_o}, {25'h0, e.mr, e.mw, e.dest});
    e = wbq.pop_front();
    check_val("wb", {25'h0, wb_regwrite_o, wb_memtoreg_o, wb_dest_o}, {25'h0, e.rw, e.mtr, e.dest});
    check_val("stall_cnt", {28'h0, stall_cnt_o}, m_sc);
    check_val("flush_cnt", {28'h0, flush_cnt_o}, m_fc);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    check_val("rst_ex", {11'h0, ex_aluop_o, ex_alusrc_o, ex_branch_o, ex_bne_o, ex_rs_o, ex_rt_o, ex_dest_o}, 32'h0);
    check_val("rst_mem", {25'h0, mem_read_o, mem_write_o, mem_dest_o}, 32'h0);
    check_val("rst_wb", {25'h0, wb_regwrite_o, wb_memtoreg_o, wb_dest_o}, 32'h0);
    check_val("rst_cnt", {24'h0, stall_cnt_o, flush_cnt_o}, 32'h0);
    exq.delete(); memq.delete(); wbq.delete();
    memq.push_back('0);
    wbq.push_back('0);
    wbq.push_back('0);
    m_ex = '0; m_sc = 0; m_fc = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    instr_i = 32'h0;
    br_taken_i = 1'b0;
    #1;
    do_reset();

    // decode sweep over all opcodes plus an undefined one and the zero word
    step(mk(6'h00, 5'd1, 5'd2, 5'd3), 1'b0);
    step(mk(6'h2B, 5'd1, 5'd4, 5'd0), 1'b0);
    step(mk(6'h04, 5'd1, 5'd4, 5'd0), 1'b0);
    step(mk(6'h05, 5'd1, 5'd4, 5'd0), 1'b0);
    step(mk(6'h08, 5'd1, 5'd5, 5'd0), 1'b0);
    step(mk(6'h0C, 5'd1, 5'd6, 5'd0), 1'b0);
    step(mk(6'h0D, 5'd1, 5'd7, 5'd0), 1'b0);
    step(mk(6'h0A, 5'd1, 5'd9, 5'd0), 1'b0);
    step(mk(6'h23, 5'd1, 5'd10, 5'd0), 1'b0);
    step(mk(6'h02, 5'd1, 5'd2, 5'd3), 1'b0);
    step(mk(6'h3F, 5'd1, 5'd2, 5'd3), 1'b0);
    for (int i = 0; i < 4; i++) step(32'h0, 1'b0);

    // load-use with rt=8, then the same pattern with rt=0
    step(mk(6'h23, 5'd0, 5'd8, 5'd0), 1'b0);
    step(mk(6'h00, 5'd8, 5'd2, 5'd3), 1'b0);
    step(mk(6'h00, 5'd8, 5'd2, 5'd3), 1'b0);
    step(mk(6'h23, 5'd0, 5'd0, 5'd0), 1'b0);
    step(mk(6'h00, 5'd0, 5'd0, 5'd3), 1'b0);
    for (int i = 0; i < 3; i++) step(32'h0, 1'b0);

    // branch taken coincident with a load-use condition
    step(mk(6'h23, 5'd0, 5'd8, 5'd0), 1'b0);
    step(mk(6'h00, 5'd8, 5'd2, 5'd3), 1'b1);
    step(32'h0, 1'b0);

    // jump
    step(mk(6'h02, 5'd3, 5'd4, 5'd5), 1'b0);
    for (int i = 0; i < 3; i++) step(32'h0, 1'b0);

    // reset with loads in flight
    step(mk(6'h23, 5'd1, 5'd11, 5'd0), 1'b0);
    step(mk(6'h23, 5'd1, 5'd12, 5'd0), 1'b0);
    do_reset();
    for (int i = 0; i < 3; i++) step(32'h0, 1'b0);

    // lw $8,($8) held: stalls every other cycle, counter must saturate at 15
    for (int i = 0; i < 40; i++) step(mk(6'h23, 5'd8, 5'd8, 5'd0), 1'b0);
    for (int i = 0; i < 3; i++) step(32'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
